// File: rtl/crc16_frame_serializer.sv
// Byte-to-bit serializer feeding a serial CRC-16 engine: buffers up to two
// bytes, streams them MSB-first without gaps, clears the engine and captures its result.
//
// state   | meaning
// IDLE    | waiting for a buffered byte
// CLEAR   | engine reset pulse, first byte loaded
// SHIFT   | data bits on bit_out, next byte chained at bit 0
// PAD     | 16 augmentation zeros
// CAPTURE | engine register final, latch into crc_out
module crc16_frame_serializer #(
  parameter bit AUGMENT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        crc_clr,
  input  logic [15:0] crc_lfsr,
  output logic [15:0] crc_out,
  output logic        crc_done,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_PAD,
    ST_CAPTURE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_mem_data [2];
  logic [1:0]  r_mem_last;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [7:0]  r_shreg;
  logic        r_last_q;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_pad_cnt;
  logic        r_bit_valid;
  logic        r_crc_clr;
  logic        r_crc_done;
  logic        r_underrun;
  logic [15:0] r_crc_out;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_head_data;
  logic        w_head_last;

  assign w_full      = (r_count == 2'd2);
  assign w_empty     = (r_count == 2'd0);
  assign w_push      = s_valid && !w_full;
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_head_last = r_mem_last[r_rd_ptr];
  // CLEAR is only entered with a byte buffered, so its pop never underflows
  assign w_pop = (r_state == ST_CLEAR) ||
                 ((r_state == ST_SHIFT) && (r_bit_cnt == 3'd7) && !r_last_q && !w_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= s_data;
        r_mem_last[r_wr_ptr] <= s_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_last_q    <= 1'b0;
      r_bit_cnt   <= '0;
      r_pad_cnt   <= '0;
      r_bit_valid <= 1'b0;
      r_crc_clr   <= 1'b0;
      r_crc_done  <= 1'b0;
      r_underrun  <= 1'b0;
      r_crc_out   <= '0;
    end else begin
      r_crc_clr  <= 1'b0;
      r_crc_done <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_valid <= 1'b0;
          if (!w_empty) begin
            r_state   <= ST_CLEAR;
            r_crc_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_shreg     <= w_head_data;
          r_last_q    <= w_head_last;
          r_bit_cnt   <= '0;
          r_bit_valid <= 1'b1;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_bit_cnt == 3'd7) begin
            if (r_last_q) begin
              r_shreg <= r_shreg << 1;
              if (AUGMENT) begin
                r_pad_cnt <= '0;
                r_state   <= ST_PAD;
              end else begin
                r_bit_valid <= 1'b0;
                r_state     <= ST_CAPTURE;
              end
            end else if (!w_empty) begin
              r_shreg   <= w_head_data;
              r_last_q  <= w_head_last;
              r_bit_cnt <= '0;
            end else begin
              r_shreg     <= r_shreg << 1;
              r_bit_valid <= 1'b0;
              r_underrun  <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_shreg   <= r_shreg << 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_PAD: begin
          if (r_pad_cnt == 4'd15) begin
            r_bit_valid <= 1'b0;
            r_state     <= ST_CAPTURE;
          end else begin
            r_pad_cnt <= r_pad_cnt + 4'd1;
          end
        end
        ST_CAPTURE: begin
          r_crc_out  <= crc_lfsr;
          r_crc_done <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_bit_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = !w_full;
  assign bit_out   = r_shreg[7] && r_bit_valid;
  assign bit_valid = r_bit_valid;
  assign crc_clr   = r_crc_clr;
  assign crc_out   = r_crc_out;
  assign crc_done  = r_crc_done;
  assign underrun  = r_underrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_crc16_frame_serializer.sv
// Bench for crc16_frame_serializer: one instance per AUGMENT setting, each with a
// serial CRC-16 (0x1021, zero init) engine; checksums predicted by polynomial long division.
module tb_crc16_frame_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;

  logic        rdy0, rdy1, bo0, bo1, bv0, bv1, clr0, clr1, dn0, dn1, un0, un1, bz0, bz1;
  logic [15:0] lfsr0, lfsr1, co0, co1;

  crc16_frame_serializer #(.AUGMENT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && (sel == 1'b0)),
    .s_last(s_last), .s_ready(rdy0), .bit_out(bo0), .bit_valid(bv0), .crc_clr(clr0),
    .crc_lfsr(lfsr0), .crc_out(co0), .crc_done(dn0), .underrun(un0), .busy(bz0));

  crc16_frame_serializer #(.AUGMENT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && (sel == 1'b1)),
    .s_last(s_last), .s_ready(rdy1), .bit_out(bo1), .bit_valid(bv1), .crc_clr(clr1),
    .crc_lfsr(lfsr1), .crc_out(co1), .crc_done(dn1), .underrun(un1), .busy(bz1));

  wire        w_rdy = sel ? rdy1 : rdy0;
  wire        w_bo  = sel ? bo1  : bo0;
  wire        w_bv  = sel ? bv1  : bv0;
  wire        w_clr = sel ? clr1 : clr0;
  wire        w_dn  = sel ? dn1  : dn0;
  wire        w_un  = sel ? un1  : un0;
  wire        w_bz  = sel ? bz1  : bz0;
  wire [15:0] w_co  = sel ? co1  : co0;

  // serial engine stand-in: shifts crc_in every clock, synchronous clear
  function automatic logic [15:0] eng_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr0 <= '0;
      lfsr1 <= '0;
    end else begin
      lfsr0 <= clr0 ? 16'h0000 : eng_step(lfsr0, bo0);
      lfsr1 <= clr1 ? 16'h0000 : eng_step(lfsr1, bo1);
    end
  end

  // remainder of (stream * x^16) mod x^16+x^12+x^5+1
  function automatic logic [15:0] crc_model(input logic q[$]);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < q.size() + 16; i++) begin
      b   = (i < q.size()) ? q[i] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  int   cyc = 0;
  logic q_bits[$];
  int   q_clr[$], q_done[$], q_unr[$];
  int   last_bit_cyc = 0;
  int   stream_err = 0, zero_err = 0, both_err = 0;
  logic prev_bv = 1'b0, prev_clr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (w_bv) begin
        if (!prev_bv && !prev_clr) stream_err++;
        q_bits.push_back(w_bo);
        last_bit_cyc = cyc;
      end else if (w_bo) begin
        zero_err++;
      end
      if (w_clr) q_clr.push_back(cyc);
      if (w_dn)  q_done.push_back(cyc);
      if (w_un)  q_unr.push_back(cyc);
      if (w_dn && w_un) both_err++;
      prev_bv  = w_bv;
      prev_clr = w_clr;
    end
  end

  int   n_pass = 0, n_total = 0;
  logic stalled;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!w_rdy && t < 300) begin
      stalled = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!w_rdy) chk("push_timeout", 64'(w_rdy), 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (q_done.size() < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (q_done.size() < target) chk("done_wait", 64'(q_done.size()), 64'(target));
  endtask

  task automatic run_frame(input logic s, input int n, input logic [31:0] dat,
                           input logic [31:0] exp_bits, input int maxdly,
                           input int exp_stall, input string tag);
    int          nclr, ndn;
    logic        exp_q[$];
    logic [63:0] act_w, exp_w;
    @(negedge clk);
    sel = s;
    q_bits.delete();
    nclr    = q_clr.size();
    ndn     = q_done.size();
    stalled = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxdly, 0)) @(negedge clk);
      push_byte(dat[31-8*i -: 8], i == n - 1);
    end
    wait_done(ndn + 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8 * n; i++) exp_q.push_back(exp_bits[31-i]);
    if (s) for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    act_w = '0;
    exp_w = '0;
    foreach (q_bits[i]) act_w = {act_w[62:0], q_bits[i]};
    foreach (exp_q[i])  exp_w = {exp_w[62:0], exp_q[i]};
    chk($sformatf("%s_len", tag), 64'(q_bits.size()), 64'(exp_q.size()));
    chk($sformatf("%s_bits", tag), act_w, exp_w);
    chk($sformatf("%s_crc", tag), 64'(w_co), 64'(crc_model(exp_q)));
    chk($sformatf("%s_nclr", tag), 64'(q_clr.size() - nclr), 64'd1);
    chk($sformatf("%s_ndone", tag), 64'(q_done.size() - ndn), 64'd1);
    if (q_done.size() > 0 && q_clr.size() > 0)
      chk($sformatf("%s_cycles", tag), 64'(q_done[$] - q_clr[$]), 64'(8 * n + 16 * int'(s) + 2));
    if (exp_stall >= 0) chk($sformatf("%s_stall", tag), 64'(stalled), 64'(exp_stall));
  endtask

  typedef struct {
    logic        s;
    int          n;
    logic [31:0] dat;
    logic [31:0] bits;
    int          stall;
  } vec_t;

  vec_t        tbl[5];
  int          nd, nu, nc, t;
  logic [15:0] co_prev;
  logic        zq[$];
  logic [31:0] rdat;
  logic        rs;
  int          rn;

  initial begin
    tbl[0] = '{1'b0, 3, 32'hAB195600, {24'b101010110001100101010110, 8'h00}, 1};
    tbl[1] = '{1'b1, 3, 32'hAB195600, {24'b101010110001100101010110, 8'h00}, 1};
    tbl[2] = '{1'b0, 4, 32'hDEADBEEF, 32'b11011110101011011011111011101111, 1};
    tbl[3] = '{1'b1, 2, 32'h12340000, {16'b0001001000110100, 16'h0000}, 0};
    tbl[4] = '{1'b0, 1, 32'h80000000, {8'b10000000, 24'h000000}, 0};

    sel = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 64'(rdy0), 64'd1);
    chk("rst_ready1", 64'(rdy1), 64'd1);
    chk("rst_outs0", 64'({bo0, bv0, clr0, dn0, un0, bz0}), 64'd0);
    chk("rst_outs1", 64'({bo1, bv1, clr1, dn1, un1, bz1}), 64'd0);
    chk("rst_crc", 64'({co0, co1}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'({bz0, bz1, rdy0, rdy1}), 64'b0011);

    // frame start: accept at T, IDLE at T..T+1, CLEAR at T+1..T+2, first bit next
    sel = 1'b0;
    q_bits.delete();
    nd = q_done.size();
    push_byte(8'hC5, 1'b1);
    @(negedge clk);
    chk("start_idle", 64'({w_clr, w_bz, w_bv}), 64'b000);
    @(negedge clk);
    chk("start_clear", 64'({w_clr, w_bz, w_bv}), 64'b110);
    @(negedge clk);
    chk("start_first_bit", 64'({w_clr, w_bv, w_bo}), 64'b011);
    wait_done(nd + 1);
    repeat (2) @(negedge clk);
    zq.delete();
    for (int i = 7; i >= 0; i--) zq.push_back(rdat_bit(8'hC5, i));
    chk("start_crc", 64'(w_co), 64'(crc_model(zq)));

    for (int v = 0; v < 5; v++)
      run_frame(tbl[v].s, tbl[v].n, tbl[v].dat, tbl[v].bits, 0, tbl[v].stall,
                $sformatf("tbl%0d", v));

    // underrun: one non-last byte, then nothing
    @(negedge clk);
    sel = 1'b0;
    q_bits.delete();
    nd = q_done.size();
    nu = q_unr.size();
    co_prev = w_co;
    push_byte(8'hAB, 1'b0);
    t = 0;
    while (q_unr.size() == nu && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("unr_count", 64'(q_unr.size() - nu), 64'd1);
    chk("unr_no_done", 64'(q_done.size() - nd), 64'd0);
    chk("unr_crc_kept", 64'(w_co), 64'(co_prev));
    chk("unr_busy", 64'(w_bz), 64'd0);
    chk("unr_bits", 64'(q_bits.size()), 64'd8);
    if (q_unr.size() > nu) chk("unr_timing", 64'(q_unr[$] - last_bit_cyc), 64'd1);

    // back-to-back one-byte frames
    @(negedge clk);
    sel = 1'b0;
    q_bits.delete();
    nd = q_done.size();
    nc = q_clr.size();
    push_byte(8'hFF, 1'b1);
    push_byte(8'h00, 1'b1);
    wait_done(nd + 2);
    repeat (2) @(negedge clk);
    chk("b2b_nclr", 64'(q_clr.size() - nc), 64'd2);
    chk("b2b_ndone", 64'(q_done.size() - nd), 64'd2);
    chk("b2b_bits", 64'(q_bits.size()), 64'd16);
    zq.delete();
    for (int i = 0; i < 8; i++) zq.push_back(1'b0);
    chk("b2b_crc", 64'(w_co), 64'(crc_model(zq)));
    if (q_done.size() >= nd + 2 && q_clr.size() >= nc + 2)
      chk("b2b_clr_gap", 64'(q_clr[nc+1] - q_done[nd]), 64'd1);

    for (int r = 0; r < 12; r++) begin
      rs   = 1'($urandom_range(1, 0));
      rn   = $urandom_range(4, 1);
      rdat = $urandom;
      run_frame(rs, rn, rdat, rdat, 2, -1, $sformatf("rnd%0d", r));
    end

    // reset in the middle of the second byte
    run_frame(1'b0, 1, 32'h5A000000, {8'b01011010, 24'h0}, 0, -1, "pre_rst");
    @(negedge clk);
    sel = 1'b0;
    q_bits.delete();
    nd = q_done.size();
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    t = 0;
    while (q_bits.size() < 14 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reached", 64'(q_bits.size() >= 14), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_ready", 64'({rdy0, rdy1}), 64'b11);
    chk("mid_outs0", 64'({bo0, bv0, clr0, dn0, un0, bz0}), 64'd0);
    chk("mid_crc", 64'({co0, co1}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_no_done", 64'(q_done.size() - nd), 64'd0);
    chk("mid_idle", 64'({bz0, bv0}), 64'd0);
    run_frame(1'b0, 2, 32'h5AC30000, {16'b0101101011000011, 16'h0000}, 0, 0, "post_rst");

    chk("stream_gaps", 64'(stream_err), 64'd0);
    chk("bit_out_idle_zero", 64'(zero_err), 64'd0);
    chk("done_underrun_excl", 64'(both_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic rdat_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
